ball_object_draw: RTL and testbench
===================================

Name: ball_object_draw

Overview:
- Pixel-stage consumer of hvsync_generator outputs (CounterX, CounterY, inDisplayArea, vga_h_sync, vga_v_sync).
- Owns a square ball: position updated once per frame during vertical blanking, bounces off screen edges, rendered as white pixels.
- Registered 1-bit RGB plus syncs delayed 1 cycle to stay aligned; feeds the VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- BALL_SIZE, 8, ball edge length in pixels
- STEP, 2, pixels moved per frame on each axis
- START_X, 316, ball x (left edge) after reset/serve
- START_Y, 236, ball y (top edge) after reset/serve
- SERVE_FRAMES, 60, frames held at start before motion

Ports:
- clk  input  1  system pixel clock
- reset  input  1  synchronous, active-high reset
- CounterX  input  10  current pixel column from hvsync_generator
- CounterY  input  9  current line from hvsync_generator
- inDisplayArea  input  1  high in visible region
- vga_h_sync_in  input  1  raw hsync from hvsync_generator
- vga_v_sync_in  input  1  raw vsync from hvsync_generator
- run  input  1  motion enable; low freezes ball in place
- vga_r, vga_g, vga_b  output  1 each  registered colour
- vga_h_sync, vga_v_sync  output  1 each  syncs delayed 1 cycle
- ball_x  output  10  ball left edge
- ball_y  output  9  ball top edge
- frame_tick  output  1  1-cycle pulse, start of vertical blanking

Behaviour:
- One clock domain, clk; reset is synchronous, active-high; all state changes on posedge clk.
- Reset: vga_r/g/b=0, vga_h_sync=vga_v_sync=0, frame_tick=0, ball_x=START_X, ball_y=START_Y, dir_x=1 (right), dir_y=1 (down), serve_cnt=0, state=SERVE.
- frame_tick registered: high for exactly one cycle after the cycle where CounterX==0 && CounterY==V_ACTIVE.
- FSM, 2 states; transitions evaluated only on frame_tick:
  - SERVE: ball held at START_X/START_Y; if run, serve_cnt++; when serve_cnt==SERVE_FRAMES-1 on a tick -> PLAY, serve_cnt=0. run low holds count.
  - PLAY: on tick with run=1, move ball. run=0 freezes position and direction; state held.
- X move, 11-bit arithmetic: right: if ball_x+STEP >= H_ACTIVE-BALL_SIZE then ball_x=H_ACTIVE-BALL_SIZE, dir_x=0; else ball_x+=STEP. Left: if ball_x <= STEP then ball_x=0, dir_x=1; else ball_x-=STEP.
- Y move: same rules, using V_ACTIVE, 10-bit arithmetic.
- Both axes update on the same tick; a corner hit flips both directions.
- Hit test, combinational, widened to avoid wrap: in_ball = CounterX>=ball_x && CounterX<ball_x+BALL_SIZE && CounterY>=ball_y && CounterY<ball_y+BALL_SIZE.
- Pixel registers: rgb = {3{inDisplayArea & in_ball}}; latency 1 cycle from Counter inputs. Syncs delayed by 1 register to match.
- Position changes only at the tick, which lies in blanking, so there is no tearing within a frame.
- Reset asserted mid-frame: ball, direction and FSM return to reset values on the next edge; outputs 0 until reset releases.

Optional Feature:
- BORDER_EN defined: pixels with inDisplayArea high and CounterX<4, CounterX>=H_ACTIVE-4, CounterY<4 or CounterY>=V_ACTIVE-4 drive vga_b=1. Ball (white) has priority over border. Latency unchanged.
- BORDER_EN undefined: border logic absent; only the ball is drawn.

Test Plan:
- Reset held 3 cycles, then released -> ball_x=316, ball_y=236, rgb=0, state SERVE; ball stays fixed for 60 frame_ticks with run=1, moves on tick 61 to (318,238).
- Pixel at CounterX=316, CounterY=236, inDisplayArea=1 -> rgb=111 one cycle later. At (324,236) -> rgb=000. Syncs equal inputs delayed by 1 cycle.
- Force PLAY with ball_x=630, dir_x=1, STEP=2 -> after tick ball_x=632, dir_x=0; next tick ball_x=630.
- Ball at (0,0) moving left/up with ball_x=ball_y=1 -> after tick (0,0), both directions flip; next tick (2,2).
- run=0 across 5 ticks in PLAY -> ball_x/ball_y/dir unchanged. run=1 resumes from same position.
- BORDER_EN build: pixel (2,100) -> vga_b=1 only; pixel (320,240) with ball there -> rgb=111. Non-BORDER_EN build: pixel (2,100) -> rgb=000.

Source files
------------

// File: rtl/ball_object_draw_if.sv
// rtl/ball_object_draw_if.sv - video timing in / VGA pins out bundle for ball_object_draw
//
// Purpose: groups the hvsync_generator timing signals feeding the pixel stage
//          and the registered VGA pin signals it produces.
// Signals:
//   CounterX[9:0], CounterY[8:0], inDisplayArea  - current pixel position / visibility
//   vga_h_sync_in, vga_v_sync_in                 - raw syncs from the timing generator
//   vga_r, vga_g, vga_b                          - registered 1-bit colour
//   vga_h_sync, vga_v_sync                       - syncs delayed one cycle
// Modports: master drives timing and observes pins; slave is the pixel stage.
interface ball_object_draw_if;
  logic [9:0] CounterX;
  logic [8:0] CounterY;
  logic       inDisplayArea;
  logic       vga_h_sync_in;
  logic       vga_v_sync_in;
  logic       vga_r;
  logic       vga_g;
  logic       vga_b;
  logic       vga_h_sync;
  logic       vga_v_sync;

  modport master (
    output CounterX, CounterY, inDisplayArea, vga_h_sync_in, vga_v_sync_in,
    input  vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync
  );

  modport slave (
    input  CounterX, CounterY, inDisplayArea, vga_h_sync_in, vga_v_sync_in,
    output vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync
  );
endinterface

// File: rtl/ball_object_draw.sv
// rtl/ball_object_draw.sv - bouncing square ball renderer for a VGA pixel stream
//
// Purpose: owns a square ball that serves from a fixed start point, then moves
//          STEP pixels per frame on each axis during vertical blanking, bouncing
//          off the screen edges. Pixels inside the ball are drawn white, with a
//          one-cycle registered pipeline (syncs delayed to match).
// Optional: define BORDER_EN to draw a 4-pixel blue border around the visible
//           area (ball has priority over the border).
// Ports:
//   clk, reset      - pixel clock, synchronous active-high reset
//   vid             - ball_object_draw_if.slave (timing in, VGA pins out)
//   run             - motion enable; low freezes ball and serve count
//   ball_x, ball_y  - ball top-left corner
//   frame_tick      - one-cycle pulse at the start of vertical blanking
module ball_object_draw #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int STEP         = 2,
  parameter int START_X      = 316,
  parameter int START_Y      = 236,
  parameter int SERVE_FRAMES = 60
) (
  input  logic                     clk,
  input  logic                     reset,
  ball_object_draw_if.slave        vid,
  input  logic                     run,
  output logic [9:0]               ball_x,
  output logic [8:0]               ball_y,
  output logic                     frame_tick
);

  localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [9:0]  Y_MAX  = 10'(V_ACTIVE - BALL_SIZE);
  localparam logic [10:0] STEP_X = 11'(STEP);
  localparam logic [9:0]  STEP_Y = 10'(STEP);
  localparam logic [10:0] SIZE_X = 11'(BALL_SIZE);
  localparam logic [9:0]  SIZE_Y = 10'(BALL_SIZE);
  localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);

  typedef enum logic {SERVE = 1'b0, PLAY = 1'b1} state_t;

  state_t      r_state, w_state_next;
  logic [7:0]  r_serve_cnt;
  logic [9:0]  r_ball_x;
  logic [8:0]  r_ball_y;
  logic        r_dir_x, r_dir_y;
  logic        r_frame_tick;
  logic        r_r, r_g, r_b, r_hs, r_vs;

  logic        w_move, w_serve_inc, w_serve_done;
  logic [10:0] w_x_plus, w_x_minus;
  logic [9:0]  w_y_plus, w_y_minus;
  logic        w_in_ball, w_white, w_border;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= SERVE;
    else       r_state <= w_state_next;
  end

  // Next state: only a frame tick can move the FSM
  always_comb begin
    w_state_next = r_state;
    if (r_state == SERVE && r_frame_tick && run && r_serve_cnt == SERVE_LAST)
      w_state_next = PLAY;
  end

  // FSM outputs: datapath control strobes
  always_comb begin
    w_move       = 1'b0;
    w_serve_inc  = 1'b0;
    w_serve_done = 1'b0;
    if (r_frame_tick && run) begin
      if (r_state == PLAY)                 w_move       = 1'b1;
      else if (r_serve_cnt == SERVE_LAST)  w_serve_done = 1'b1;
      else                                 w_serve_inc  = 1'b1;
    end
  end

  // Widened arithmetic so the edge compares never wrap
  assign w_x_plus  = {1'b0, r_ball_x} + STEP_X;
  assign w_x_minus = {1'b0, r_ball_x} - STEP_X;
  assign w_y_plus  = {1'b0, r_ball_y} + STEP_Y;
  assign w_y_minus = {1'b0, r_ball_y} - STEP_Y;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_tick <= 1'b0;
      r_serve_cnt  <= '0;
      r_ball_x     <= 10'(START_X);
      r_ball_y     <= 9'(START_Y);
      r_dir_x      <= 1'b1;
      r_dir_y      <= 1'b1;
    end else begin
      r_frame_tick <= (vid.CounterX == 10'd0) && ({1'b0, vid.CounterY} == 10'(V_ACTIVE));
      if (w_serve_inc)  r_serve_cnt <= r_serve_cnt + 8'd1;
      if (w_serve_done) r_serve_cnt <= '0;
      if (w_move) begin
        if (r_dir_x) begin
          if (w_x_plus >= X_MAX) begin
            r_ball_x <= X_MAX[9:0];
            r_dir_x  <= 1'b0;
          end else begin
            r_ball_x <= w_x_plus[9:0];
          end
        end else begin
          if ({1'b0, r_ball_x} <= STEP_X) begin
            r_ball_x <= '0;
            r_dir_x  <= 1'b1;
          end else begin
            r_ball_x <= w_x_minus[9:0];
          end
        end
        if (r_dir_y) begin
          if (w_y_plus >= Y_MAX) begin
            r_ball_y <= Y_MAX[8:0];
            r_dir_y  <= 1'b0;
          end else begin
            r_ball_y <= w_y_plus[8:0];
          end
        end else begin
          if ({1'b0, r_ball_y} <= STEP_Y) begin
            r_ball_y <= '0;
            r_dir_y  <= 1'b1;
          end else begin
            r_ball_y <= w_y_minus[8:0];
          end
        end
      end
    end
  end

  assign w_in_ball = ({1'b0, vid.CounterX} >= {1'b0, r_ball_x}) &&
                     ({1'b0, vid.CounterX} <  ({1'b0, r_ball_x} + SIZE_X)) &&
                     ({1'b0, vid.CounterY} >= {1'b0, r_ball_y}) &&
                     ({1'b0, vid.CounterY} <  ({1'b0, r_ball_y} + SIZE_Y));
  assign w_white = vid.inDisplayArea && w_in_ball;

`ifdef BORDER_EN
  assign w_border = vid.inDisplayArea &&
                    ((vid.CounterX < 10'd4) || ({1'b0, vid.CounterX} >= 11'(H_ACTIVE - 4)) ||
                     (vid.CounterY < 9'd4)  || ({1'b0, vid.CounterY} >= 10'(V_ACTIVE - 4)));
`else
  assign w_border = 1'b0;
`endif

  // Pixel pipeline: colour and syncs share one register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      r_r  <= 1'b0;
      r_g  <= 1'b0;
      r_b  <= 1'b0;
      r_hs <= 1'b0;
      r_vs <= 1'b0;
    end else begin
      r_r  <= w_white;
      r_g  <= w_white;
      r_b  <= w_white | w_border;
      r_hs <= vid.vga_h_sync_in;
      r_vs <= vid.vga_v_sync_in;
    end
  end

  assign vid.vga_r      = r_r;
  assign vid.vga_g      = r_g;
  assign vid.vga_b      = r_b;
  assign vid.vga_h_sync = r_hs;
  assign vid.vga_v_sync = r_vs;
  assign ball_x         = r_ball_x;
  assign ball_y         = r_ball_y;
  assign frame_tick     = r_frame_tick;

endmodule

// File: tb/tb_ball_object_draw.sv
// tb/tb_ball_object_draw.sv - directed self-checking bench for ball_object_draw
module tb_ball_object_draw;
  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic       frame_tick;
  int         n_checks = 0;
  int         n_fail   = 0;

  ball_object_draw_if vid ();

  ball_object_draw dut (
    .clk        (clk),
    .reset      (reset),
    .vid        (vid.slave),
    .run        (run),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] rgb();
    return {vid.vga_r, vid.vga_g, vid.vga_b};
  endfunction

  task automatic drive(input logic [9:0] x, input logic [8:0] y, input logic de,
                       input logic hs, input logic vs);
    @(negedge clk);
    vid.CounterX      = x;
    vid.CounterY      = y;
    vid.inDisplayArea = de;
    vid.vga_h_sync_in = hs;
    vid.vga_v_sync_in = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      drive(10'd0, 9'd480, 1'b0, 1'b0, 1'b0);
      drive(10'd1, 9'd480, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic chk_ball(input string name, input logic [9:0] ex, input logic [8:0] ey);
    n_checks++;
    if (ball_x !== ex || ball_y !== ey) begin
      n_fail++;
      $display("FAIL %s: got (%0d,%0d) expected (%0d,%0d)", name, ball_x, ball_y, ex, ey);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    run   = 1'b1;
    for (int i = 0; i < 3; i++) drive(10'd316, 9'd236, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (rgb() !== 3'b000 || vid.vga_h_sync !== 1'b0 || vid.vga_v_sync !== 1'b0 || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: rgb=%b hs=%b vs=%b tick=%b expected 000 0 0 0",
               rgb(), vid.vga_h_sync, vid.vga_v_sync, frame_tick);
    end
    chk_ball("reset_ball", 10'd316, 9'd236);
    reset = 1'b0;
  endtask

  task automatic test_pixels();
    drive(10'd316, 9'd236, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (rgb() !== 3'b111) begin n_fail++; $display("FAIL pix_corner: rgb=%b expected 111", rgb()); end
    drive(10'd324, 9'd236, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (rgb() !== 3'b000) begin n_fail++; $display("FAIL pix_right_out: rgb=%b expected 000", rgb()); end
    drive(10'd323, 9'd243, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (rgb() !== 3'b111) begin n_fail++; $display("FAIL pix_far_corner: rgb=%b expected 111", rgb()); end
    drive(10'd316, 9'd244, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (rgb() !== 3'b000) begin n_fail++; $display("FAIL pix_below_out: rgb=%b expected 000", rgb()); end
    drive(10'd316, 9'd236, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (rgb() !== 3'b000) begin n_fail++; $display("FAIL pix_blank: rgb=%b expected 000", rgb()); end
    drive(10'd2, 9'd100, 1'b1, 1'b0, 1'b0);
    n_checks++;
`ifdef BORDER_EN
    if (rgb() !== 3'b001) begin n_fail++; $display("FAIL pix_border: rgb=%b expected 001", rgb()); end
`else
    if (rgb() !== 3'b000) begin n_fail++; $display("FAIL pix_border: rgb=%b expected 000", rgb()); end
`endif
  endtask

  task automatic test_syncs();
    drive(10'd700, 9'd100, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (vid.vga_h_sync !== 1'b1 || vid.vga_v_sync !== 1'b0) begin
      n_fail++; $display("FAIL sync_a: hs=%b vs=%b expected 1 0", vid.vga_h_sync, vid.vga_v_sync);
    end
    drive(10'd700, 9'd100, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (vid.vga_h_sync !== 1'b0 || vid.vga_v_sync !== 1'b1) begin
      n_fail++; $display("FAIL sync_b: hs=%b vs=%b expected 0 1", vid.vga_h_sync, vid.vga_v_sync);
    end
  endtask

  // Serve tick 1, with the pulse shape checked
  task automatic test_frame_tick();
    drive(10'd0, 9'd480, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL tick_high: tick=%b expected 1", frame_tick); end
    drive(10'd1, 9'd480, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL tick_low: tick=%b expected 0", frame_tick); end
    drive(10'd0, 9'd479, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL tick_wrong_line: tick=%b expected 0", frame_tick); end
  endtask

  task automatic test_serve();
    ticks(59);
    chk_ball("serve_tick60", 10'd316, 9'd236);
    ticks(1);
    chk_ball("play_tick1", 10'd318, 9'd238);
  endtask

  task automatic test_bounce_right();
    ticks(156);
    chk_ball("play_k157", 10'd630, 9'd394);
    ticks(1);
    chk_ball("right_wall", 10'd632, 9'd392);
    ticks(1);
    chk_ball("right_rebound", 10'd630, 9'd390);
  endtask

  task automatic test_run_hold();
    run = 1'b0;
    ticks(5);
    chk_ball("run_low_hold", 10'd630, 9'd390);
    run = 1'b1;
    ticks(1);
    chk_ball("run_resume", 10'd628, 9'd388);
  endtask

  task automatic test_bounce_top();
    ticks(193);
    chk_ball("play_k353", 10'd242, 9'd2);
    ticks(1);
    chk_ball("top_wall", 10'd240, 9'd0);
    ticks(1);
    chk_ball("top_rebound", 10'd238, 9'd2);
  endtask

  task automatic test_bounce_left();
    ticks(118);
    chk_ball("play_k473", 10'd2, 9'd238);
    ticks(1);
    chk_ball("left_wall", 10'd0, 9'd240);
    ticks(1);
    chk_ball("left_rebound", 10'd2, 9'd242);
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    drive(10'd316, 9'd236, 1'b1, 1'b1, 1'b1);
    chk_ball("midreset_ball", 10'd316, 9'd236);
    n_checks++;
    if (rgb() !== 3'b000 || vid.vga_h_sync !== 1'b0 || vid.vga_v_sync !== 1'b0) begin
      n_fail++; $display("FAIL midreset_out: rgb=%b hs=%b vs=%b expected 000 0 0",
                         rgb(), vid.vga_h_sync, vid.vga_v_sync);
    end
    reset = 1'b0;
    drive(10'd316, 9'd236, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (rgb() !== 3'b111) begin n_fail++; $display("FAIL midreset_pix: rgb=%b expected 111", rgb()); end
    ticks(60);
    chk_ball("midreset_serve", 10'd316, 9'd236);
    ticks(1);
    chk_ball("midreset_play", 10'd318, 9'd238);
  endtask

  initial begin
    vid.CounterX      = '0;
    vid.CounterY      = '0;
    vid.inDisplayArea = 1'b0;
    vid.vga_h_sync_in = 1'b0;
    vid.vga_v_sync_in = 1'b0;
    reset = 1'b1;
    run   = 1'b1;
    test_reset();
    test_pixels();
    test_syncs();
    test_frame_tick();
    test_serve();
    test_bounce_right();
    test_run_hold();
    test_bounce_top();
    test_bounce_left();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
